booth_mult_seq: RTL and testbench
=================================

Name: booth_mult_seq

Overview:
- Parametrised iterative radix-4 Booth multiplier; next generation of the combinational 8x8 Booth/CLA multiplier.
- Generalised to any even operand width, with a signed/unsigned mode selected per operation.
- Retires one Booth digit per clock into a single accumulator instead of building a full partial-product tree, trading latency for area.
- Sits between the operand capture latches and the output latches, using valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >= 4. Product is 2*WIDTH bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode are presented.
- in_ready  output  1  block can accept an operation (state IDLE).
- signed_mode  input  1  1 = two's-complement operands; 0 = unsigned operands. Sampled on accept.
- mcand  input  WIDTH  multiplicand. Sampled on accept.
- mlier  input  WIDTH  multiplier. Sampled on accept.
- out_valid  output  1  product is valid.
- out_ready  input  1  consumer accepts the product.
- product  output  2*WIDTH  result. Signed or unsigned according to the mode captured at accept.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst high at an edge):
  - state returns to IDLE.
  - product, accumulator, counter and operand registers clear to 0.
  - out_valid = 0, busy = 0.
  - in_ready = 0 while rst is high; in_ready = 1 in the first cycle after rst falls.
  - Reset has priority over every other event, including mid-RUN and DONE; an in-flight operation is discarded with no output.
- States: IDLE, RUN, DONE.
  - in_ready = (state == IDLE) && !rst.
  - out_valid = (state == DONE).
- Accept: an edge where in_valid && in_ready.
  - Capture mcand, signed_mode, and mlier extended with a 0 appended below bit 0.
  - Multiplier extension above bit WIDTH-1: sign-extended if signed_mode, zero-extended otherwise.
  - Clear the accumulator; set the digit counter to 0; go to RUN.
  - in_valid while not in IDLE is ignored.
- Digit count N:
  - N = WIDTH/2 when signed_mode = 1.
  - N = WIDTH/2 + 1 when signed_mode = 0; the extra digit covers the unsigned top bit.
- RUN, one digit per edge:
  - Digit i uses multiplier triplet {m[2i+1], m[2i], m[2i-1]} with m[-1] = 0.
  - Encoding to {0, +1, +2, -1, -2} x mcand follows the existing booth_encoding table: 000/111 = 0, 001/010 = +1, 011 = +2, 100 = -2, 101/110 = -1.
  - Partial product: mcand extended to 2*WIDTH+2 bits (sign-extended if signed_mode, else zero-extended). Negative digits use the two's complement.
  - The partial product is shifted left by 2i and added to the accumulator modulo 2^(2*WIDTH+2).
  - After the edge that processes digit N-1: product <= accumulator[2*WIDTH-1:0], go to DONE.
  - Latency: out_valid first high exactly N cycles after the accept edge (4 signed / 5 unsigned at WIDTH=8).
- DONE:
  - product and out_valid hold stable for any length of out_ready low.
  - An edge with out_ready high goes to IDLE. out_valid drops and in_ready rises in the next cycle.
  - Throughput: one operation per N+2 cycles minimum.
- product keeps its last value after leaving DONE until the next completion or a reset.
- Boundary cases:
  - Signed most-negative x most-negative gives a positive result with no overflow.
  - Unsigned all-ones x all-ones gives 2^(2W) - 2^(W+1) + 1.
  - A zero operand still takes the full N cycles; there is no early termination.

Test Plan:
- WIDTH=8, signed, mcand=7, mlier=-3 (0xFD) -> product=0xFFEB (-21); out_valid exactly 4 cycles after accept.
- WIDTH=8, unsigned, 0xFF x 0xFF -> product=0xFE01 (65025); 5-cycle latency. The same operands in signed mode -> 0x0001.
- WIDTH=8, signed, 0x80 x 0x80 -> 0x4000. Then 0x80 x 0x7F -> 0xC080 (-16256).
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and operands -> product and out_valid stable, in_ready=0, no new accept. Release -> in_ready=1 next cycle.
- Reset mid-operation: assert rst in the 2nd RUN cycle -> next cycle out_valid=0, product=0, in_ready=1 once rst falls. A fresh 3 x 5 then returns 15.
- WIDTH=16 and WIDTH=4: 1000 random operand/mode pairs with random out_ready stalls, checked against a behavioural signed/unsigned multiply model. Latency must be WIDTH/2 or WIDTH/2+1.

Source files
------------

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier: one Booth digit retired per clock
// into a single accumulator, with valid/ready handshakes on both sides.
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mlier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int PW = 2*WIDTH + 2;
    localparam int MW = WIDTH + 3;
    localparam int CW = $clog2(WIDTH/2 + 2);

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
        $error("booth_mult_seq: WIDTH must be even and >= 4");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   mc;
    logic [MW-1:0]   ml;
    logic [CW-1:0]   cnt;
    logic            sgn;

    logic [PW-1:0]   pp;
    logic [PW-1:0]   acc_nxt;
    logic [CW-1:0]   cnt_last;
    logic            ext_mc;
    logic            ext_ml;

    assign ext_mc = signed_mode & mcand[WIDTH-1];
    assign ext_ml = signed_mode & mlier[WIDTH-1];

    // Unsigned operands need one extra digit to absorb the top bit.
    assign cnt_last = sgn ? CW'(WIDTH/2 - 1) : CW'(WIDTH/2);

    // mc is pre-shifted by 2 per digit, so the low triplet of ml
    // always lines up with the current weight.
    always_comb begin
        pp = '0;
        unique case (ml[2:0])
            3'b001, 3'b010: pp = mc;
            3'b011:         pp = mc << 1;
            3'b100:         pp = -(mc << 1);
            3'b101, 3'b110: pp = -mc;
            default:        pp = '0;
        endcase
    end

    assign acc_nxt = acc + pp;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            mc      <= '0;
            ml      <= '0;
            cnt     <= '0;
            sgn     <= 1'b0;
            product <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        mc    <= {{(WIDTH+2){ext_mc}}, mcand};
                        ml    <= {{2{ext_ml}}, mlier, 1'b0};
                        sgn   <= signed_mode;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    mc  <= mc << 2;
                    ml  <= ml >> 2;
                    cnt <= cnt + 1'b1;
                    if (cnt == cnt_last) begin
                        product <= acc_nxt[2*WIDTH-1:0];
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and random checks for booth_mult_seq at WIDTH 8, 4 and 16.
module tb_booth_mult_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        in_valid, in_ready, signed_mode, out_valid, out_ready, busy;
    logic [7:0]  mcand, mlier;
    logic [15:0] product;

    logic        d4_in_valid, d4_in_ready, d4_sm, d4_out_valid;
    logic        d4_out_ready, d4_busy;
    logic [3:0]  d4_a, d4_b;
    logic [7:0]  d4_p;

    logic        d16_in_valid, d16_in_ready, d16_sm, d16_out_valid;
    logic        d16_out_ready, d16_busy;
    logic [15:0] d16_a, d16_b;
    logic [31:0] d16_p;

    booth_mult_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .signed_mode(signed_mode), .mcand(mcand), .mlier(mlier),
        .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy)
    );

    booth_mult_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(d4_in_valid), .in_ready(d4_in_ready),
        .signed_mode(d4_sm), .mcand(d4_a), .mlier(d4_b),
        .out_valid(d4_out_valid), .out_ready(d4_out_ready),
        .product(d4_p), .busy(d4_busy)
    );

    booth_mult_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(d16_in_valid), .in_ready(d16_in_ready),
        .signed_mode(d16_sm), .mcand(d16_a), .mlier(d16_b),
        .out_valid(d16_out_valid), .out_ready(d16_out_ready),
        .product(d16_p), .busy(d16_busy)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          sm;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic op8(input bit sm, input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] p, output int lat);
        chk("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        signed_mode = sm;
        mcand = a;
        mlier = b;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        p = product;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("in_ready_after_done", in_ready, 1);
    endtask

    task automatic rand4();
        bit sm;
        logic [3:0] a, b;
        logic [7:0] e;
        longint sa, sb;
        int lat;
        for (int k = 0; k < 1000; k++) begin
            sm = 1'($urandom_range(0, 1));
            a = 4'($urandom);
            b = 4'($urandom);
            sa = sm ? longint'($signed(a)) : longint'(a);
            sb = sm ? longint'($signed(b)) : longint'(b);
            e = 8'(sa * sb);
            chk("w4_in_ready", d4_in_ready, 1);
            d4_in_valid = 1'b1;
            d4_sm = sm;
            d4_a = a;
            d4_b = b;
            tick();
            d4_in_valid = 1'b0;
            lat = 0;
            while (!d4_out_valid && lat < 40) begin
                tick();
                lat++;
            end
            repeat ($urandom_range(0, 3)) tick();
            chk("w4_product", d4_p, e);
            chk("w4_latency", lat, sm ? 2 : 3);
            d4_out_ready = 1'b1;
            tick();
            d4_out_ready = 1'b0;
        end
    endtask

    task automatic rand16();
        bit sm;
        logic [15:0] a, b;
        logic [31:0] e;
        longint sa, sb;
        int lat;
        for (int k = 0; k < 1000; k++) begin
            sm = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            b = 16'($urandom);
            sa = sm ? longint'($signed(a)) : longint'(a);
            sb = sm ? longint'($signed(b)) : longint'(b);
            e = 32'(sa * sb);
            chk("w16_in_ready", d16_in_ready, 1);
            d16_in_valid = 1'b1;
            d16_sm = sm;
            d16_a = a;
            d16_b = b;
            tick();
            d16_in_valid = 1'b0;
            lat = 0;
            while (!d16_out_valid && lat < 40) begin
                tick();
                lat++;
            end
            repeat ($urandom_range(0, 3)) tick();
            chk("w16_product", d16_p, e);
            chk("w16_latency", lat, sm ? 8 : 9);
            d16_out_ready = 1'b1;
            tick();
            d16_out_ready = 1'b0;
        end
    endtask

    initial begin
        logic [15:0] p;
        int lat;

        vecs[0]  = '{1'b1, 8'h07, 8'hFD, 16'hFFEB, 4};
        vecs[1]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 5};
        vecs[2]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001, 4};
        vecs[3]  = '{1'b1, 8'h80, 8'h80, 16'h4000, 4};
        vecs[4]  = '{1'b1, 8'h80, 8'h7F, 16'hC080, 4};
        vecs[5]  = '{1'b0, 8'h00, 8'hFF, 16'h0000, 5};
        vecs[6]  = '{1'b1, 8'h00, 8'h00, 16'h0000, 4};
        vecs[7]  = '{1'b0, 8'h80, 8'h80, 16'h4000, 5};
        vecs[8]  = '{1'b1, 8'h7F, 8'h7F, 16'h3F01, 4};
        vecs[9]  = '{1'b0, 8'h0C, 8'h0D, 16'h009C, 5};
        vecs[10] = '{1'b1, 8'h03, 8'h05, 16'h000F, 4};
        vecs[11] = '{1'b1, 8'hFE, 8'h05, 16'hFFF6, 4};

        rst = 1'b1;
        in_valid = 1'b0; signed_mode = 1'b0; mcand = '0; mlier = '0;
        out_ready = 1'b0;
        d4_in_valid = 1'b0; d4_sm = 1'b0; d4_a = '0; d4_b = '0;
        d4_out_ready = 1'b0;
        d16_in_valid = 1'b0; d16_sm = 1'b0; d16_a = '0; d16_b = '0;
        d16_out_ready = 1'b0;

        repeat (3) tick();
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_product", product, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_reset", in_ready, 1);

        for (int i = 0; i < 12; i++) begin
            op8(vecs[i].sm, vecs[i].a, vecs[i].b, p, lat);
            chk($sformatf("vec%0d_product", i), p, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        // Backpressure: hold DONE while the input side churns.
        in_valid = 1'b1; signed_mode = 1'b0; mcand = 8'h12; mlier = 8'h34;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("bp_latency", lat, 5);
        for (int c = 0; c < 10; c++) begin
            in_valid = ~in_valid;
            signed_mode = ~signed_mode;
            mcand = 8'($urandom);
            mlier = 8'($urandom);
            tick();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_product", product, 16'h03A8);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_busy", busy, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_out_valid", out_valid, 0);
        chk("bp_product_held", product, 16'h03A8);

        // Reset in the second RUN cycle discards the operation.
        in_valid = 1'b1; signed_mode = 1'b1; mcand = 8'h55; mlier = 8'h66;
        tick();
        in_valid = 1'b0;
        tick();
        chk("mid_run_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_high_in_ready", in_ready, 0);
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_product", product, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        #1;
        chk("rst_fall_in_ready", in_ready, 1);
        repeat (3) tick();
        chk("rst_no_late_output", out_valid, 0);
        op8(1'b1, 8'h03, 8'h05, p, lat);
        chk("post_rst_product", p, 16'h000F);
        chk("post_rst_latency", lat, 4);

        rand4();
        rand16();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
